// File: rtl/spi_pixel_bridge_pkg.sv
// Shared pixel width and pixel type for the SPI bridge and the grayscale/Sobel datapath.
package spi_pixel_bridge_pkg;
  localparam int MAX_PIXEL_BITS = 8;
  typedef logic [MAX_PIXEL_BITS-1:0] pixel_t;
endpackage

// File: rtl/spi_pixel_bridge_fifo.sv
// pixel_fifo: synchronous FIFO, power-of-2 depth, registered occupancy count.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push on a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
endmodule

// File: rtl/spi_pixel_bridge.sv
// Clock-domain bridge between the SCK-domain SPI shifter and the clk_i pixel datapath:
// byte-done detection, RX/TX FIFOs, sticky error flags and the registered transmit byte.
module spi_pixel_bridge
  import spi_pixel_bridge_pkg::*;
#(
  parameter int                        RX_DEPTH = 4,
  parameter int                        TX_DEPTH = 4,
  parameter logic [MAX_PIXEL_BITS-1:0] TX_FILL  = 8'h00
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      cs_i,
  input  logic [MAX_PIXEL_BITS-1:0] spi_rx_i,
  input  logic                      spi_done_i,
  output logic [MAX_PIXEL_BITS-1:0] spi_tx_o,
  output logic [MAX_PIXEL_BITS-1:0] px_data_o,
  output logic                      px_valid_o,
  input  logic                      px_ready_i,
  input  logic [MAX_PIXEL_BITS-1:0] res_data_i,
  input  logic                      res_valid_i,
  output logic                      res_ready_o,
  output logic                      rx_ovf_o,
  output logic                      tx_unf_o
);
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic       cs_p0, cs_p1;
  logic       done_p0, done_p1, done_p2;
  logic       byte_evt;

  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic       tx_push, tx_pop, tx_empty, tx_full;
  pixel_t     tx_head;
  pixel_t     spi_tx_q;
  logic [RX_CW-1:0] rx_count_unused;
  logic [TX_CW-1:0] tx_count_unused;

  // Stage p0/p1: two-flop synchronizers; p2: previous done level for edge detection.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cs_p0   <= 1'b0;
      cs_p1   <= 1'b0;
      done_p0 <= 1'b0;
      done_p1 <= 1'b0;
      done_p2 <= 1'b0;
    end else begin
      cs_p0   <= cs_i;
      cs_p1   <= cs_p0;
      done_p0 <= spi_done_i;
      done_p1 <= done_p0;
      done_p2 <= done_p1;
    end
  end

  // done_p2 follows done_p1 every cycle, so while CS is idle any done transition is
  // absorbed and the level is already re-seeded when CS goes active again.
  assign byte_evt = (done_p1 ^ done_p2) & ~cs_p1;

  assign rx_pop  = ~rx_empty & px_ready_i;
  assign rx_push = byte_evt & (~rx_full | rx_pop);

  assign tx_pop      = byte_evt & ~tx_empty;
  assign res_ready_o = ~tx_full | tx_pop;
  assign tx_push     = res_valid_i & res_ready_o;

  pixel_fifo #(.DEPTH(RX_DEPTH), .WIDTH(MAX_PIXEL_BITS)) u_rx_fifo (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .push     (rx_push),
    .pop      (rx_pop),
    .din      (spi_rx_i),
    .dout     (px_data_o),
    .empty    (rx_empty),
    .full     (rx_full),
    .count    (rx_count_unused)
  );

  pixel_fifo #(.DEPTH(TX_DEPTH), .WIDTH(MAX_PIXEL_BITS)) u_tx_fifo (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .push     (tx_push),
    .pop      (tx_pop),
    .din      (res_data_i),
    .dout     (tx_head),
    .empty    (tx_empty),
    .full     (tx_full),
    .count    (tx_count_unused)
  );

  assign px_valid_o = ~rx_empty;

  // Stage p3: sticky flags and the transmit byte presented to the shifter.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      rx_ovf_o <= 1'b0;
      tx_unf_o <= 1'b0;
      spi_tx_q <= TX_FILL;
    end else begin
      if (byte_evt && rx_full && !rx_pop) rx_ovf_o <= 1'b1;
      if (byte_evt && tx_empty)           tx_unf_o <= 1'b1;
      spi_tx_q <= tx_empty ? TX_FILL : tx_head;
    end
  end

  assign spi_tx_o = spi_tx_q;
endmodule

// File: tb/tb_spi_pixel_bridge.sv
// Directed bench for spi_pixel_bridge: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_spi_pixel_bridge;
  localparam int         RXD  = 4;
  localparam int         TXD  = 4;
  localparam logic [7:0] FILL = 8'h00;

  logic       clk = 1'b0;
  logic       nreset_i = 1'b0;
  logic       cs_i = 1'b0;
  logic [7:0] spi_rx_i = 8'h00;
  logic       spi_done_i = 1'b0;
  logic [7:0] spi_tx_o;
  logic [7:0] px_data_o;
  logic       px_valid_o;
  logic       px_ready_i = 1'b0;
  logic [7:0] res_data_i = 8'h00;
  logic       res_valid_i = 1'b0;
  logic       res_ready_o;
  logic       rx_ovf_o;
  logic       tx_unf_o;

  always #5 clk = ~clk;

  spi_pixel_bridge #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .TX_FILL(FILL)) dut (
    .clk_i       (clk),
    .nreset_i    (nreset_i),
    .cs_i        (cs_i),
    .spi_rx_i    (spi_rx_i),
    .spi_done_i  (spi_done_i),
    .spi_tx_o    (spi_tx_o),
    .px_data_o   (px_data_o),
    .px_valid_o  (px_valid_o),
    .px_ready_i  (px_ready_i),
    .res_data_i  (res_data_i),
    .res_valid_i (res_valid_i),
    .res_ready_o (res_ready_o),
    .rx_ovf_o    (rx_ovf_o),
    .tx_unf_o    (tx_unf_o)
  );

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte event is due 3 edges after each expected done toggle.
  int         cyc = 0;
  bit         ev_at  [0:4095];
  logic [7:0] ev_dat [0:4095];
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] tx_m = FILL;
  bit         ovf_m = 1'b0;
  bit         unf_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge nreset_i) begin : model
    bit ev;
    bit rdy;
    if (!nreset_i) begin
      rxq.delete();
      txq.delete();
      tx_m  = FILL;
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      ev   = ev_at[cyc];
      tx_m = (txq.size() > 0) ? txq[0] : FILL;
      rdy  = (txq.size() < TXD) || (ev && txq.size() > 0);
      if (rxq.size() > 0 && px_ready_i) void'(rxq.pop_front());
      if (ev) begin
        if (rxq.size() < RXD) rxq.push_back(ev_dat[cyc]);
        else ovf_m = 1'b1;
        if (txq.size() > 0) void'(txq.pop_front());
        else unf_m = 1'b1;
      end
      if (res_valid_i && rdy) txq.push_back(res_data_i);
    end
  end

  always @(negedge clk) begin
    chk("px_valid", px_valid_o, rxq.size() > 0);
    if (rxq.size() > 0) chk("px_data", px_data_o, rxq[0]);
    chk("res_ready", res_ready_o, (txq.size() < TXD) || (ev_at[cyc] && txq.size() > 0));
    chk("spi_tx", spi_tx_o, tx_m);
    chk("rx_ovf", rx_ovf_o, ovf_m);
    chk("tx_unf", tx_unf_o, unf_m);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI byte: flip done, hold data for a full SCK period of 8 clk_i cycles.
  task automatic send_byte(input logic [7:0] d, input bit expect_ev);
    spi_rx_i   = d;
    spi_done_i = ~spi_done_i;
    if (expect_ev) begin
      ev_at[cyc+2]  = 1'b1;
      ev_dat[cyc+2] = d;
    end
    tick(8);
  endtask

  task automatic pop_px(input logic [7:0] exp, input string name);
    chk({name, "_valid"}, px_valid_o, 1'b1);
    chk(name, px_data_o, exp);
    px_ready_i = 1'b1;
    tick(1);
    px_ready_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    nreset_i = 1'b1;
    chk("rst_px_valid", px_valid_o, 1'b0);
    chk("rst_res_ready", res_ready_o, 1'b1);
    chk("rst_spi_tx", spi_tx_o, 8'h00);
    chk("rst_rx_ovf", rx_ovf_o, 1'b0);
    chk("rst_tx_unf", tx_unf_o, 1'b0);
    tick(4);
    chk("no_spurious_evt", px_valid_o, 1'b0);

    // Queue two result bytes for transmission.
    res_valid_i = 1'b1;
    res_data_i  = 8'h11;
    tick(1);
    res_data_i  = 8'h22;
    tick(1);
    res_valid_i = 1'b0;
    tick(2);
    chk("tx_head_11", spi_tx_o, 8'h11);

    // First byte with explicit 3-cycle event latency.
    spi_rx_i   = 8'hA5;
    spi_done_i = ~spi_done_i;
    ev_at[cyc+2]  = 1'b1;
    ev_dat[cyc+2] = 8'hA5;
    tick(1);
    chk("lat_e1", px_valid_o, 1'b0);
    tick(1);
    chk("lat_e2", px_valid_o, 1'b0);
    tick(1);
    chk("lat_e3", px_valid_o, 1'b1);
    chk("lat_e3_data", px_data_o, 8'hA5);
    tick(5);
    chk("tx_head_22", spi_tx_o, 8'h22);
    chk("tx_unf_after1", tx_unf_o, 1'b0);

    send_byte(8'h3C, 1'b1);
    chk("tx_fill_after2", spi_tx_o, 8'h00);
    chk("tx_unf_after2", tx_unf_o, 1'b0);
    send_byte(8'h5A, 1'b1);
    chk("tx_unf_after3", tx_unf_o, 1'b1);
    chk("tx_fill_after3", spi_tx_o, 8'h00);

    pop_px(8'hA5, "rx_order0");
    pop_px(8'h3C, "rx_order1");
    pop_px(8'h5A, "rx_order2");
    chk("rx_drained", px_valid_o, 1'b0);

    // Overflow: five bytes into a four-entry FIFO with no consumer.
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 4) chk("no_ovf_at_4", rx_ovf_o, 1'b0);
    end
    chk("ovf_at_5", rx_ovf_o, 1'b1);
    for (int i = 1; i <= 4; i++) pop_px(8'(i), "ovf_drain");
    chk("ovf_drained", px_valid_o, 1'b0);

    send_byte(8'h66, 1'b1);
    pop_px(8'h66, "pre_cs");

    // Done falls 1->0 while CS is idle: must not be captured.
    cs_i = 1'b1;
    tick(6);
    send_byte(8'hEE, 1'b0);
    cs_i = 1'b0;
    tick(6);
    chk("cs_no_push", px_valid_o, 1'b0);
    send_byte(8'h77, 1'b1);
    pop_px(8'h77, "after_cs");

    // Asynchronous reset with three RX entries and one TX entry queued.
    send_byte(8'h81, 1'b1);
    send_byte(8'h82, 1'b1);
    send_byte(8'h83, 1'b1);
    res_valid_i = 1'b1;
    res_data_i  = 8'h99;
    tick(1);
    res_valid_i = 1'b0;
    tick(2);
    chk("pre_rst_valid", px_valid_o, 1'b1);
    chk("pre_rst_tx", spi_tx_o, 8'h99);
    #2;
    nreset_i = 1'b0;
    #1;
    chk("mid_rst_px_valid", px_valid_o, 1'b0);
    chk("mid_rst_rx_ovf", rx_ovf_o, 1'b0);
    chk("mid_rst_tx_unf", tx_unf_o, 1'b0);
    chk("mid_rst_res_ready", res_ready_o, 1'b1);
    chk("mid_rst_spi_tx", spi_tx_o, 8'h00);
    tick(2);
    nreset_i = 1'b1;
    tick(5);
    chk("post_rst_px_valid", px_valid_o, 1'b0);
    chk("post_rst_spi_tx", spi_tx_o, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
